// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and operand/operation codes for the serial add/subtract engine
package addsub_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam logic SEL_A  = 1'b0;
  localparam logic SEL_B  = 1'b1;
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial SIZE-bit add/subtract, LSB first, with start/busy/done handshake
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] in,
  input  logic            sel,
  input  logic            ld,
  input  logic            start,
  input  logic            op,
  input  logic            CI,
  output logic [SIZE-1:0] SUM,
  output logic            CO,
  output logic            busy,
  output logic            done
);
  localparam int CW = $clog2(SIZE + 1);
  state_t          state;
  logic [SIZE-1:0] a_q, b_q, res;
  logic [CW-1:0]   cnt;
  logic            c, op_q, b_eff, r, c_nxt;
  // subtraction adds the inverted B bit; the carry then acts as an inverted borrow
  assign b_eff = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
  serial_fa_cell u_fa (
    .a   (a_q[0]),
    .b   (b_eff),
    .cin (c),
    .s   (r),
    .cout(c_nxt)
  );
  // control FSM, operand/result shifters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      res   <= '0;
      c     <= 1'b0;
      op_q  <= OP_ADD;
      cnt   <= '0;
      SUM   <= '0;
      CO    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            c     <= (op == OP_SUB) ? ~CI : CI;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else if (ld) begin
            if (sel == SEL_A) a_q <= in;
            else b_q <= in;
          end
        end
        ST_SHIFT: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          res <= {r, res[SIZE-1:1]};
          c   <= c_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SIZE - 1)) begin
            SUM   <= {r, res[SIZE-1:1]};
            CO    <= (op_q == OP_SUB) ? ~c_nxt : c_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: table-driven scoreboard bench for serial_addsub
module tb_serial_addsub;
  localparam int SIZE = 16;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [SIZE-1:0] in = '0;
  logic            sel = 1'b0, ld = 1'b0, start = 1'b0, op = 1'b0, ci = 1'b0;
  logic [SIZE-1:0] sum;
  logic            co, busy, done;
  typedef struct {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            op;
    logic            ci;
    logic [SIZE-1:0] sum;
    logic            co;
  } vec_t;
  typedef struct {
    logic [SIZE-1:0] sum;
    logic            co;
  } exp_t;
  exp_t            sb[$];
  vec_t            vecs[6];
  int              checks = 0, errors = 0;
  logic [SIZE-1:0] last_sum = '0;
  logic            last_co = 1'b0;
  serial_addsub #(.SIZE(SIZE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .sel  (sel),
    .ld   (ld),
    .start(start),
    .op   (op),
    .CI   (ci),
    .SUM  (sum),
    .CO   (co),
    .busy (busy),
    .done (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic load(input logic s, input logic [SIZE-1:0] v);
    @(negedge clk);
    ld = 1'b1; sel = s; in = v;
    @(negedge clk);
    ld = 1'b0;
  endtask
  task automatic run(input vec_t v, input int inj, input int rst_at);
    int   busy_cnt = 0, done_cnt = 0, done_at = -1;
    exp_t e;
    load(1'b0, v.a);
    load(1'b1, v.b);
    if (rst_at < 0) sb.push_back('{v.sum, v.co});
    @(negedge clk);
    start = 1'b1; op = v.op; ci = v.ci;
    for (int i = 0; i < SIZE + 4; i++) begin
      @(negedge clk);
      start = 1'b0; ld = 1'b0; rst_n = 1'b1;
      if (i == inj) begin
        start = 1'b1; ld = 1'b1; sel = 1'b0; in = 16'd99;
      end
      if (rst_at >= 0 && i == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_mid_sum", sum, 0);
        chk("rst_mid_co", co, 0);
        chk("rst_mid_busy", busy, 0);
        last_sum = '0; last_co = 1'b0;
      end
      if (busy) begin
        busy_cnt++;
        if (sum !== last_sum || co !== last_co) chk("hold_during_shift", {co, sum}, {last_co, last_sum});
      end
      if (done) begin
        done_cnt++;
        done_at = i;
        chk("busy_low_at_done", busy, 0);
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sum", sum, e.sum);
          chk("co", co, e.co);
          last_sum = e.sum; last_co = e.co;
        end
      end
    end
    if (rst_at >= 0) chk("no_done_after_reset", done_cnt, 0);
    else begin
      chk("done_count", done_cnt, 1);
      chk("done_latency", done_at, SIZE);
      chk("busy_cycles", busy_cnt, SIZE);
    end
  endtask
  initial begin
    vecs[0] = '{16'd3,     16'd16, 1'b0, 1'b0, 16'd19,    1'b0};
    vecs[1] = '{16'd104,   16'd16, 1'b1, 1'b1, 16'd87,    1'b0};
    vecs[2] = '{16'd3,     16'd16, 1'b1, 1'b0, 16'hFFF3,  1'b1};
    vecs[3] = '{16'hFFFF,  16'd1,  1'b0, 1'b0, 16'h0000,  1'b1};
    vecs[4] = '{16'h0000,  16'h0,  1'b0, 1'b1, 16'h0001,  1'b0};
    vecs[5] = '{16'h0000,  16'h0,  1'b1, 1'b1, 16'hFFFF,  1'b1};
    repeat (2) @(negedge clk);
    chk("reset_sum", sum, 0);
    chk("reset_co", co, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) run(vecs[k], -1, -1);
    run('{16'd30, 16'd16, 1'b0, 1'b0, 16'd46, 1'b0}, 4, -1);
    run('{16'd500, 16'd21, 1'b0, 1'b0, 16'd521, 1'b0}, -1, 7);
    run('{16'd1234, 16'd4321, 1'b0, 1'b1, 16'd5556, 1'b0}, -1, -1);
    run('{16'd100, 16'd200, 1'b1, 1'b0, 16'hFF9C, 1'b1}, -1, -1);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
